// File: rtl/mm2s_stream_framer.sv
// Cuts an untagged AXIS beat stream into command-sized frames and re-emits it with tlast
// through a one-deep output register slice, counting frames delivered downstream.
module mm2s_stream_framer #(
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    logic slotFree;
    logic cmdFire;
    logic inFire;
    logic outFire;

    // The slice can take a new beat when empty or when its beat leaves this same cycle.
    assign slotFree      = !tvalid_q || m_axis_tready;
    assign cmd_ready     = aresetn && (state_q == IDLE);
    assign s_axis_tready = (state_q == STREAM) && slotFree;

    assign cmdFire = cmd_valid && cmd_ready;
    assign inFire  = s_axis_tvalid && s_axis_tready;
    assign outFire = tvalid_q && m_axis_tready;

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q == STREAM) || tvalid_q;
    assign frame_count   = count_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        count_d     = count_q;

        if (state_q == IDLE) begin
            if (cmdFire) begin
                remaining_d = cmd_len;
                state_d     = STREAM;
            end
        end else begin
            if (inFire) begin
                if (remaining_q == '0) begin
                    state_d = IDLE;
                end else begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                end
            end
        end

        // A new load takes priority over draining so back-to-back beats keep full throughput.
        if (inFire) begin
            tdata_d  = s_axis_tdata;
            tvalid_d = 1'b1;
            tlast_d  = (remaining_q == '0);
        end else if (outFire) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        if (outFire && tlast_q) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            count_q     <= count_d;
        end
    end

endmodule
